// File: rtl/inst_buffer_if.sv
// Fetch/decode-side signal bundle for the instruction buffer.
// The slave modport is the buffer's view; the master modport is fetch plus decoder.
interface inst_buffer_if;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_pc1;
  logic [31:0] fetch_pc2;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_inst2;
  logic [1:0]  fetch_pretaken;
  logic [31:0] fetch_pre_addr1;
  logic [31:0] fetch_pre_addr2;
  logic        fetch_pc_exc1;
  logic        fetch_pc_exc2;
  logic [6:0]  fetch_pc_cause1;
  logic [6:0]  fetch_pc_cause2;
  logic [1:0]  fetch_bus_err;
  logic        fetch_stall;
  logic        get_data_req;
  logic        pause_decoder;
  logic [1:0]  valid;
  logic [31:0] pc1;
  logic [31:0] pc2;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic [1:0]  pretaken;
  logic [31:0] pre_addr_in1;
  logic [31:0] pre_addr_in2;
  logic [1:0]  is_exception_in1;
  logic [1:0]  is_exception_in2;
  logic [6:0]  pc_exception_cause_in1;
  logic [6:0]  pc_exception_cause_in2;
  logic [6:0]  instbuffer_exception_cause_in1;
  logic [6:0]  instbuffer_exception_cause_in2;

  modport slave (
    input  fetch_valid, fetch_pc1, fetch_pc2, fetch_inst1, fetch_inst2, fetch_pretaken,
           fetch_pre_addr1, fetch_pre_addr2, fetch_pc_exc1, fetch_pc_exc2,
           fetch_pc_cause1, fetch_pc_cause2, fetch_bus_err, get_data_req, pause_decoder,
    output fetch_stall, valid, pc1, pc2, inst1, inst2, pretaken, pre_addr_in1, pre_addr_in2,
           is_exception_in1, is_exception_in2, pc_exception_cause_in1, pc_exception_cause_in2,
           instbuffer_exception_cause_in1, instbuffer_exception_cause_in2
  );

  modport master (
    output fetch_valid, fetch_pc1, fetch_pc2, fetch_inst1, fetch_inst2, fetch_pretaken,
           fetch_pre_addr1, fetch_pre_addr2, fetch_pc_exc1, fetch_pc_exc2,
           fetch_pc_cause1, fetch_pc_cause2, fetch_bus_err, get_data_req, pause_decoder,
    input  fetch_stall, valid, pc1, pc2, inst1, inst2, pretaken, pre_addr_in1, pre_addr_in2,
           is_exception_in1, is_exception_in2, pc_exception_cause_in1, pc_exception_cause_in2,
           instbuffer_exception_cause_in1, instbuffer_exception_cause_in2
  );
endinterface

// File: rtl/inst_buffer.sv
// Dual-issue fetch-to-decode instruction queue: compacts up to two fetched slots per cycle
// into a circular FIFO and issues the two oldest entries per cycle to the decoder.
module inst_buffer #(
  parameter int         DEPTH      = 16,
  parameter logic [6:0] IBUF_ECODE = 7'h08
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  inst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pretaken;
    logic [31:0] pre_addr;
    logic        pc_exc;
    logic [6:0]  pc_cause;
    logic        bus_err;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [1:0]    r_valid;
  entry_t        r_out1;
  entry_t        r_out2;

  entry_t        w_slot0;
  entry_t        w_slot1;
  entry_t        w_wr0;
  logic [AW:0]   w_free;
  logic          w_stall;
  logic          w_enq_ok;
  logic [1:0]    w_n_enq;
  logic          w_issue_ok;
  logic [1:0]    w_new_valid;
  logic [1:0]    w_n_deq;
  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;

  assign w_slot0 = '{pc: bus.fetch_pc1, inst: bus.fetch_inst1, pretaken: bus.fetch_pretaken[0],
                     pre_addr: bus.fetch_pre_addr1, pc_exc: bus.fetch_pc_exc1,
                     pc_cause: bus.fetch_pc_cause1, bus_err: bus.fetch_bus_err[0]};
  assign w_slot1 = '{pc: bus.fetch_pc2, inst: bus.fetch_inst2, pretaken: bus.fetch_pretaken[1],
                     pre_addr: bus.fetch_pre_addr2, pc_exc: bus.fetch_pc_exc2,
                     pc_cause: bus.fetch_pc_cause2, bus_err: bus.fetch_bus_err[1]};

  // Stall looks only at the registered count, so fetch never sees a dequeue-dependent path.
  assign w_free   = DEPTH_C - r_count;
  assign w_stall  = w_free < (AW+1)'(2);
  assign w_enq_ok = !w_stall;
  assign w_n_enq  = w_enq_ok ? ({1'b0, bus.fetch_valid[0]} + {1'b0, bus.fetch_valid[1]}) : 2'd0;
  assign w_wr0    = bus.fetch_valid[0] ? w_slot0 : w_slot1;
  assign w_tail1  = r_tail + AW'(1);
  assign w_head1  = r_head + AW'(1);

  assign w_issue_ok  = bus.get_data_req && !bus.pause_decoder;
  assign w_new_valid = {r_count >= (AW+1)'(2), r_count >= (AW+1)'(1)};
  assign w_n_deq     = w_issue_ok ? ({1'b0, w_new_valid[0]} + {1'b0, w_new_valid[1]}) : 2'd0;

  // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq_ok && !flush) begin
      if (bus.fetch_valid != 2'b00) r_mem[r_tail]  <= w_wr0;
      if (bus.fetch_valid == 2'b11) r_mem[w_tail1] <= w_slot1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 2'b00;
      r_out1  <= '0;
      r_out2  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 2'b00;
    end else begin
      r_head  <= r_head + AW'(w_n_deq);
      r_tail  <= r_tail + AW'(w_n_enq);
      r_count <= r_count + (AW+1)'(w_n_enq) - (AW+1)'(w_n_deq);
      if (w_issue_ok) begin
        r_valid <= w_new_valid;
        r_out1  <= r_mem[r_head];
        r_out2  <= r_mem[w_head1];
      end else begin
        r_valid <= 2'b00;
      end
    end
  end

  assign bus.fetch_stall    = w_stall;
  assign bus.valid          = r_valid;
  assign bus.pc1            = r_out1.pc;
  assign bus.pc2            = r_out2.pc;
  assign bus.inst1          = r_out1.inst;
  assign bus.inst2          = r_out2.inst;
  assign bus.pretaken       = {r_out2.pretaken, r_out1.pretaken};
  assign bus.pre_addr_in1   = r_out1.pre_addr;
  assign bus.pre_addr_in2   = r_out2.pre_addr;
  assign bus.is_exception_in1 = {r_out1.pc_exc, r_out1.bus_err};
  assign bus.is_exception_in2 = {r_out2.pc_exc, r_out2.bus_err};
  assign bus.pc_exception_cause_in1 = r_out1.pc_exc ? r_out1.pc_cause : 7'd0;
  assign bus.pc_exception_cause_in2 = r_out2.pc_exc ? r_out2.pc_cause : 7'd0;
  assign bus.instbuffer_exception_cause_in1 = r_out1.bus_err ? IBUF_ECODE : 7'd0;
  assign bus.instbuffer_exception_cause_in2 = r_out2.bus_err ? IBUF_ECODE : 7'd0;
endmodule
